// File: rtl/axi_read_arbiter_if.sv
// Bundle of the requester-side and memory-side AXI4 read channels of axi_read_arbiter.
// master: the arbiter's view (it masters the memory port); slave: the surrounding logic.
interface axi_read_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_axi_araddr;
  logic [NUM_PORTS*8-1:0]          s_axi_arlen;
  logic [NUM_PORTS-1:0]            s_axi_arvalid;
  logic [NUM_PORTS-1:0]            s_axi_arready;
  logic [DATA_WIDTH-1:0]           s_axi_rdata;
  logic [1:0]                      s_axi_rresp;
  logic                            s_axi_rlast;
  logic [NUM_PORTS-1:0]            s_axi_rvalid;
  logic [NUM_PORTS-1:0]            s_axi_rready;

  logic [ID_WIDTH-1:0]             m_axi_arid;
  logic [ADDR_WIDTH-1:0]           m_axi_araddr;
  logic [7:0]                      m_axi_arlen;
  logic [2:0]                      m_axi_arsize;
  logic [1:0]                      m_axi_arburst;
  logic                            m_axi_arvalid;
  logic                            m_axi_arready;
  logic [DATA_WIDTH-1:0]           m_axi_rdata;
  logic [1:0]                      m_axi_rresp;
  logic                            m_axi_rlast;
  logic                            m_axi_rvalid;
  logic                            m_axi_rready;

  modport master (
    input  s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port among NUM_PORTS requesters, one burst at a time, round-robin.
// Define RD_ARB_FIXED_PRIORITY_EN for strict lowest-index-wins priority instead.
module axi_read_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic                aclk,
  input logic                resetn,
  axi_read_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      grant_q;
  logic [IDX_W-1:0]      winner;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic                  req_any;
  logic                  accept;
  logic                  last_beat;

  assign req_any   = |bus.s_axi_arvalid;
  assign accept    = (state_q == StIdle) && req_any;
  assign last_beat = (state_q == StData) && bus.m_axi_rvalid && bus.m_axi_rready &&
                     bus.m_axi_rlast;

`ifdef RD_ARB_FIXED_PRIORITY_EN
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (bus.s_axi_arvalid[i]) winner = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q;

  // Scan starts just past the previous grant so every requester gets a turn.
  always_comb begin
    int unsigned cand;
    logic        found;
    cand   = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_PORTS;
      if (!found && bus.s_axi_arvalid[cand]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
    end else if (last_beat) begin
      last_grant_q <= grant_q;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_any) state_d = StAddr;
      StAddr:  if (bus.m_axi_arready) state_d = StData;
      StData:  if (last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q  <= winner;
        araddr_q <= bus.s_axi_araddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        arlen_q  <= bus.s_axi_arlen[int'(winner)*8 +: 8];
        arid_q   <= ID_WIDTH'(winner);
      end
    end
  end

  // Memory beats are only accepted while a burst is routed; elsewhere they back-pressure.
  always_comb begin
    bus.s_axi_arready = '0;
    bus.s_axi_rvalid  = '0;
    bus.m_axi_rready  = 1'b0;
    if (accept) bus.s_axi_arready[winner] = 1'b1;
    if (state_q == StData) begin
      bus.m_axi_rready          = bus.s_axi_rready[grant_q];
      bus.s_axi_rvalid[grant_q] = bus.m_axi_rvalid;
    end
  end

  assign bus.m_axi_arvalid = (state_q == StAddr);
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arid    = arid_q;
  assign bus.m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign bus.m_axi_arburst = 2'b01;

  assign bus.s_axi_rdata = bus.m_axi_rdata;
  assign bus.s_axi_rresp = bus.m_axi_rresp;
  assign bus.s_axi_rlast = bus.m_axi_rlast;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: table of arbitration bursts plus hand-written corner
// sequences (address stall, read back-pressure, back-to-back bursts, reset mid-burst).
module tb_axi_read_arbiter;
  localparam int unsigned NP  = 4;
  localparam int unsigned IDW = 8;
  localparam int unsigned AW  = 25;
  localparam int unsigned DW  = 64;

`ifdef RD_ARB_FIXED_PRIORITY_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_read_arbiter_if #(.NUM_PORTS(NP), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW))
    arb_bus ();

  axi_read_arbiter #(.NUM_PORTS(NP), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (arb_bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NP-1:0] req;
    logic [7:0]    len;
    int            exp_rr;
    int            exp_fp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [7:0] l);
    arb_bus.s_axi_araddr[p*AW +: AW] = a;
    arb_bus.s_axi_arlen[p*8 +: 8]    = l;
  endtask

  task automatic clear_inputs();
    arb_bus.s_axi_araddr  = '0;
    arb_bus.s_axi_arlen   = '0;
    arb_bus.s_axi_arvalid = '0;
    arb_bus.s_axi_rready  = '1;
    arb_bus.m_axi_arready = 1'b0;
    arb_bus.m_axi_rdata   = '0;
    arb_bus.m_axi_rresp   = '0;
    arb_bus.m_axi_rlast   = 1'b0;
    arb_bus.m_axi_rvalid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
  endtask

  // One full burst from table entry idx; port p asks for address base+0x40*p, length len+p.
  task automatic do_burst(input int idx);
    vec_t            v;
    int              g;
    int              nbeats;
    logic [AW-1:0]   exp_addr;
    logic [7:0]      exp_len;
    logic [DW-1:0]   exp_data;
    v        = vecs[idx];
    g        = FixedPrio ? v.exp_fp : v.exp_rr;
    exp_addr = AW'(32'h1000 * (idx + 1) + 32'h40 * g);
    exp_len  = v.len + 8'(g);
    nbeats   = int'(exp_len) + 1;
    @(negedge aclk);
    for (int p = 0; p < int'(NP); p++) begin
      set_req(p, AW'(32'h1000 * (idx + 1) + 32'h40 * p), v.len + 8'(p));
    end
    arb_bus.s_axi_arvalid = v.req;
    #1;
    check("grant_arready", 64'(arb_bus.s_axi_arready), 64'(1 << g));
    check("idle_no_arvalid", 64'(arb_bus.m_axi_arvalid), 64'd0);
    @(negedge aclk);
    arb_bus.s_axi_arvalid = '0;
    arb_bus.s_axi_araddr  = '1;
    arb_bus.s_axi_arlen   = '1;
    #1;
    check("addr_arvalid", 64'(arb_bus.m_axi_arvalid), 64'd1);
    check("addr_araddr", 64'(arb_bus.m_axi_araddr), 64'(exp_addr));
    check("addr_arlen", 64'(arb_bus.m_axi_arlen), 64'(exp_len));
    check("addr_arid", 64'(arb_bus.m_axi_arid), 64'(g));
    check("addr_no_arready", 64'(arb_bus.s_axi_arready), 64'd0);
    arb_bus.m_axi_arready = 1'b1;
    @(negedge aclk);
    arb_bus.m_axi_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      exp_data             = DW'((idx << 8) | b);
      arb_bus.m_axi_rvalid = 1'b1;
      arb_bus.m_axi_rdata  = exp_data;
      arb_bus.m_axi_rresp  = 2'(b);
      arb_bus.m_axi_rlast  = (b == nbeats - 1);
      #1;
      check("beat_rvalid", 64'(arb_bus.s_axi_rvalid), 64'(1 << g));
      check("beat_rdata", 64'(arb_bus.s_axi_rdata), 64'(exp_data));
      check("beat_rresp", 64'(arb_bus.s_axi_rresp), 64'(b & 3));
      check("beat_rlast", 64'(arb_bus.s_axi_rlast), 64'(b == nbeats - 1));
      check("beat_m_rready", 64'(arb_bus.m_axi_rready), 64'd1);
      @(negedge aclk);
    end
    arb_bus.m_axi_rvalid = 1'b0;
    arb_bus.m_axi_rlast  = 1'b0;
  endtask

  initial begin
    int beat;
    int cyc;
    int phase;
    int g;
    logic stall;

    vecs[0] = '{4'b0001, 8'd3, 0, 0};
    vecs[1] = '{4'b0011, 8'd0, 1, 0};
    vecs[2] = '{4'b0011, 8'd1, 0, 0};
    vecs[3] = '{4'b1010, 8'd0, 1, 1};
    vecs[4] = '{4'b1010, 8'd2, 3, 1};
    vecs[5] = '{4'b1111, 8'd0, 0, 0};
    vecs[6] = '{4'b0100, 8'd1, 2, 2};
    vecs[7] = '{4'b1001, 8'd0, 3, 0};
    vecs[8] = '{4'b1001, 8'd0, 0, 0};

    clear_inputs();
    do_reset();

    // Reset state, with a stray memory beat present while idle.
    arb_bus.m_axi_rvalid = 1'b1;
    arb_bus.m_axi_rlast  = 1'b1;
    #1;
    check("rst_arvalid", 64'(arb_bus.m_axi_arvalid), 64'd0);
    check("rst_araddr", 64'(arb_bus.m_axi_araddr), 64'd0);
    check("rst_arlen", 64'(arb_bus.m_axi_arlen), 64'd0);
    check("rst_arid", 64'(arb_bus.m_axi_arid), 64'd0);
    check("rst_arready", 64'(arb_bus.s_axi_arready), 64'd0);
    check("idle_stray_rvalid", 64'(arb_bus.s_axi_rvalid), 64'd0);
    check("idle_stray_rready", 64'(arb_bus.m_axi_rready), 64'd0);
    check("arsize", 64'(arb_bus.m_axi_arsize), 64'd3);
    check("arburst", 64'(arb_bus.m_axi_arburst), 64'd1);
    @(negedge aclk);
    arb_bus.m_axi_rvalid = 1'b0;
    arb_bus.m_axi_rlast  = 1'b0;

    for (int i = 0; i < 9; i++) do_burst(i);

    // Address stall for 5 cycles, then read back-pressure for 3 cycles.
    @(negedge aclk);
    set_req(0, 25'h100, 8'd3);
    arb_bus.s_axi_arvalid = 4'b0001;
    #1;
    check("stall_grant", 64'(arb_bus.s_axi_arready), 64'b0001);
    @(negedge aclk);
    set_req(0, 25'h0, 8'd0);
    set_req(1, 25'h1ff, 8'd5);
    arb_bus.s_axi_arvalid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_arvalid", 64'(arb_bus.m_axi_arvalid), 64'd1);
      check("stall_araddr", 64'(arb_bus.m_axi_araddr), 64'h100);
      check("stall_arlen", 64'(arb_bus.m_axi_arlen), 64'd3);
      check("stall_no_arready", 64'(arb_bus.s_axi_arready), 64'd0);
      @(negedge aclk);
    end
    arb_bus.m_axi_arready = 1'b1;
    @(negedge aclk);
    arb_bus.m_axi_arready = 1'b0;
    arb_bus.s_axi_arvalid = '0;
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 30) begin
      stall                   = (cyc >= 2 && cyc < 5);
      arb_bus.s_axi_rready[0] = !stall;
      arb_bus.m_axi_rvalid    = 1'b1;
      arb_bus.m_axi_rdata     = DW'(64'ha0 + beat);
      arb_bus.m_axi_rlast     = (beat == 3);
      #1;
      check("bp_m_rready", 64'(arb_bus.m_axi_rready), 64'(!stall));
      check("bp_rvalid", 64'(arb_bus.s_axi_rvalid), 64'b0001);
      check("bp_rdata", 64'(arb_bus.s_axi_rdata), 64'ha0 + 64'(beat));
      if (arb_bus.m_axi_rready) beat++;
      @(negedge aclk);
      cyc++;
    end
    check("bp_beat_count", 64'(beat), 64'd4);
    check("bp_cycle_count", 64'(cyc), 64'd7);
    arb_bus.s_axi_rready = '1;
    arb_bus.m_axi_rvalid = 1'b0;
    arb_bus.m_axi_rlast  = 1'b0;

    // Back-to-back single-beat bursts from ports 0 and 1: 3-cycle period, 1 idle bubble.
    do_reset();
    set_req(0, 25'h200, 8'd0);
    set_req(1, 25'h300, 8'd0);
    arb_bus.s_axi_arvalid = 4'b0011;
    arb_bus.m_axi_arready = 1'b1;
    arb_bus.m_axi_rvalid  = 1'b1;
    arb_bus.m_axi_rlast   = 1'b1;
    for (int c = 0; c < 12; c++) begin
      phase = c % 3;
      g     = FixedPrio ? 0 : (c / 3) % 2;
      #1;
      check("b2b_arready", 64'(arb_bus.s_axi_arready), (phase == 0) ? 64'(1 << g) : 64'd0);
      check("b2b_rvalid", 64'(arb_bus.s_axi_rvalid), (phase == 2) ? 64'(1 << g) : 64'd0);
      check("b2b_m_rready", 64'(arb_bus.m_axi_rready), 64'(phase == 2));
      if (phase == 1) check("b2b_arid", 64'(arb_bus.m_axi_arid), 64'(g));
      @(negedge aclk);
    end

    // Reset during beat 2 of an 8-beat burst from port 1.
    do_reset();
    set_req(1, 25'h400, 8'd7);
    arb_bus.s_axi_arvalid = 4'b0010;
    #1;
    check("rst_burst_grant", 64'(arb_bus.s_axi_arready), 64'b0010);
    @(negedge aclk);
    arb_bus.s_axi_arvalid = '0;
    arb_bus.m_axi_arready = 1'b1;
    @(negedge aclk);
    arb_bus.m_axi_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      arb_bus.m_axi_rvalid = 1'b1;
      arb_bus.m_axi_rdata  = DW'(b);
      #1;
      check("rst_burst_rvalid", 64'(arb_bus.s_axi_rvalid), 64'b0010);
      if (b < 2) @(negedge aclk);
    end
    #1 resetn = 1'b0;
    #1;
    check("async_rst_rvalid", 64'(arb_bus.s_axi_rvalid), 64'd0);
    check("async_rst_m_rready", 64'(arb_bus.m_axi_rready), 64'd0);
    check("async_rst_arvalid", 64'(arb_bus.m_axi_arvalid), 64'd0);
    check("async_rst_arready", 64'(arb_bus.s_axi_arready), 64'd0);
    @(negedge aclk);
    resetn               = 1'b1;
    arb_bus.m_axi_rvalid = 1'b0;
    set_req(0, 25'h500, 8'd0);
    set_req(1, 25'h600, 8'd0);
    arb_bus.s_axi_arvalid = 4'b0011;
    #1;
    check("post_rst_grant", 64'(arb_bus.s_axi_arready), 64'b0001);
    @(negedge aclk);
    arb_bus.s_axi_arvalid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
